// File: rtl/ahb_slave_with_pcie_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports on one clock.
// Same-address collisions: s1 wins on shared byte lanes; a cross-port read sees pre-write data.
module ahb_slave_with_pcie_onchip_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_en;
  logic                  w_wr1, w_wr2, w_rd1, w_rd2;
  logic [DATA_WIDTH-1:0] r_rd1_q, r_rd2_q;
  logic                  r_rd1_v, r_rd2_v;
  logic [DATA_WIDTH-1:0] w_q1, w_q2;
  logic                  w_v1, w_v2;

  assign w_en  = clken & ~reset_req;
  assign w_wr1 = w_en & s1_chipselect & s1_write;
  assign w_wr2 = w_en & s2_chipselect & s2_write;
  assign w_rd1 = w_en & s1_chipselect & s1_read & ~s1_write;
  assign w_rd2 = w_en & s2_chipselect & s2_read & ~s2_write;

  // s1 lanes are assigned last so they override s2 on a same-address collision.
  always_ff @(posedge clk) begin
    if (w_wr2) begin
      for (int b = 0; b < NB; b++) begin
        if (s2_byteenable[b]) r_mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
    end
    if (w_wr1) begin
      for (int b = 0; b < NB; b++) begin
        if (s1_byteenable[b]) r_mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
    end
  end

  // Array sampled with non-blocking semantics, so a read racing a write returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd1_q <= '0;
      r_rd2_q <= '0;
      r_rd1_v <= 1'b0;
      r_rd2_v <= 1'b0;
    end else if (w_en) begin
      r_rd1_v <= w_rd1;
      r_rd2_v <= w_rd2;
      if (w_rd1) r_rd1_q <= r_mem[s1_address];
      if (w_rd2) r_rd2_q <= r_mem[s2_address];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_out1_q, r_out2_q;
    logic                  r_out1_v, r_out2_v;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_out1_q <= '0;
        r_out2_q <= '0;
        r_out1_v <= 1'b0;
        r_out2_v <= 1'b0;
      end else if (w_en) begin
        r_out1_v <= r_rd1_v;
        r_out2_v <= r_rd2_v;
        if (r_rd1_v) r_out1_q <= r_rd1_q;
        if (r_rd2_v) r_out2_q <= r_rd2_q;
      end
    end

    assign w_q1 = r_out1_q;
    assign w_q2 = r_out2_q;
    assign w_v1 = r_out1_v;
    assign w_v2 = r_out2_v;
  end else begin : g_lat1
    assign w_q1 = r_rd1_q;
    assign w_q2 = r_rd2_q;
    assign w_v1 = r_rd1_v;
    assign w_v2 = r_rd2_v;
  end

  // A held valid is only presented on enabled cycles so a stall delays the pulse instead of stretching it.
  assign s1_readdata      = w_q1;
  assign s2_readdata      = w_q2;
  assign s1_readdatavalid = w_v1 & w_en;
  assign s2_readdatavalid = w_v2 & w_en;

endmodule

// File: tb/tb_ahb_slave_with_pcie_onchip_memory_dp.sv
// Scoreboard bench: two DUTs (read latency 1 and 2) share stimulus; a reference memory
// predicts read data and the enabled-edge count at which each valid must appear.
module tb_ahb_slave_with_pcie_onchip_memory_dp;
  logic        clk = 1'b0;
  logic        reset, reset_req, clken;
  logic [9:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
  logic        a_s1_rv, a_s2_rv, b_s1_rv, b_s2_rv;

  logic [31:0] ref_mem [1024];
  logic [31:0] exp_d [4][$];
  int          exp_t [4][$];
  int          en_edges = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  ahb_slave_with_pcie_onchip_memory_dp #(.READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_rv),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_rv)
  );

  ahb_slave_with_pcie_onchip_memory_dp #(.READ_LATENCY(2)) u_dut_b (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_rv),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_rv)
  );

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Stream p is the latency-1 device, stream p+2 the latency-2 device.
  task automatic push(int p, logic [31:0] d);
    exp_d[p].push_back(d);
    exp_t[p].push_back(en_edges + 1);
    exp_d[p+2].push_back(d);
    exp_t[p+2].push_back(en_edges + 2);
  endtask

  task automatic tick();
    bit en;
    en = clken && !reset_req;
    if (en && !reset) begin
      if (s1_chipselect && s1_read && !s1_write) push(0, ref_mem[s1_address]);
      if (s2_chipselect && s2_read && !s2_write) push(1, ref_mem[s2_address]);
      if (s2_chipselect && s2_write)
        ref_mem[s2_address] = merge(ref_mem[s2_address], s2_writedata, s2_byteenable);
      if (s1_chipselect && s1_write)
        ref_mem[s1_address] = merge(ref_mem[s1_address], s1_writedata, s1_byteenable);
    end
    @(posedge clk);
    #1;
    if (en) en_edges++;
  endtask

  task automatic idle();
    clken = 1'b1; reset_req = 1'b0;
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    s1_byteenable = 4'h0; s2_byteenable = 4'h0;
  endtask

  task automatic p1(bit rd, bit wr, logic [9:0] a, logic [31:0] d, logic [3:0] be);
    s1_chipselect = 1'b1; s1_read = rd; s1_write = wr;
    s1_address = a; s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic p2(bit rd, bit wr, logic [9:0] a, logic [31:0] d, logic [3:0] be);
    s2_chipselect = 1'b1; s2_read = rd; s2_write = wr;
    s2_address = a; s2_writedata = d; s2_byteenable = be;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(string nm);
    chk({nm, "_a_s1_rd"}, a_s1_rd, 32'h0);
    chk({nm, "_a_s2_rd"}, a_s2_rd, 32'h0);
    chk({nm, "_b_s1_rd"}, b_s1_rd, 32'h0);
    chk({nm, "_b_s2_rd"}, b_s2_rd, 32'h0);
    chk({nm, "_a_s1_rv"}, {31'h0, a_s1_rv}, 32'h0);
    chk({nm, "_a_s2_rv"}, {31'h0, a_s2_rv}, 32'h0);
    chk({nm, "_b_s1_rv"}, {31'h0, b_s1_rv}, 32'h0);
    chk({nm, "_b_s2_rv"}, {31'h0, b_s2_rv}, 32'h0);
  endtask

  task automatic mon(int k, logic v, logic [31:0] d);
    bit          en;
    logic [31:0] ed;
    int          et;
    en = clken && !reset_req;
    if (v) begin
      n_tests++;
      if (!en) begin
        n_fail++;
        $display("FAIL valid_while_disabled stream %0d got valid=1 expected 0", k);
      end else if (exp_d[k].size() == 0) begin
        n_fail++;
        $display("FAIL spurious_valid stream %0d got data %h expected no response", k, d);
      end else begin
        ed = exp_d[k].pop_front();
        et = exp_t[k].pop_front();
        if (d !== ed || et != en_edges) begin
          n_fail++;
          $display("FAIL read_data stream %0d got %h at edge %0d expected %h at edge %0d",
                   k, d, en_edges, ed, et);
        end
      end
    end else if (en && exp_d[k].size() > 0 && exp_t[k][0] <= en_edges) begin
      n_tests++;
      n_fail++;
      ed = exp_d[k].pop_front();
      et = exp_t[k].pop_front();
      $display("FAIL missing_valid stream %0d got valid=0 expected %h at edge %0d", k, ed, et);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, a_s1_rv, a_s1_rd);
      mon(1, a_s2_rv, a_s2_rd);
      mon(2, b_s1_rv, b_s1_rd);
      mon(3, b_s2_rv, b_s2_rd);
    end
  end

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 7) < 6) return 10'($urandom_range(0, 31));
    return 10'(10'h3F0 + $urandom_range(0, 15));
  endfunction

  initial begin
    reset = 1'b1;
    s1_address = '0; s2_address = '0; s1_writedata = '0; s2_writedata = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset_state");
    reset = 1'b0;

    // Preload every address the bench ever touches.
    for (int i = 0; i < 48; i++) begin
      idle();
      p1(0, 1, (i < 32) ? 10'(i) : 10'(10'h3F0 + i - 32), $urandom, 4'hF);
      tick();
    end

    idle(); p1(0, 1, 10'h005, 32'hDEADBEEF, 4'hF); tick();
    idle(); p1(1, 0, 10'h005, 32'h0, 4'h0); tick();
    idle(); p2(0, 1, 10'h3FF, 32'hDEADBEEF, 4'hF); tick();
    idle(); p2(0, 1, 10'h3FF, 32'h11223344, 4'b0101); tick();
    idle(); p2(1, 0, 10'h3FF, 32'h0, 4'h0); tick();

    idle(); p1(0, 1, 10'h010, 32'hAAAAAAAA, 4'hF); p2(0, 1, 10'h010, 32'h55555555, 4'b1100); tick();
    idle(); p1(1, 0, 10'h010, 32'h0, 4'h0); tick();
    idle(); p1(0, 1, 10'h010, 32'hAAAAAAAA, 4'b0011); p2(0, 1, 10'h010, 32'h55555555, 4'b1100); tick();
    idle(); p2(1, 0, 10'h010, 32'h0, 4'h0); tick();

    idle(); p1(0, 1, 10'h020, 32'h0, 4'hF); tick();
    idle(); p1(0, 1, 10'h020, 32'h12345678, 4'hF); p2(1, 0, 10'h020, 32'h0, 4'h0); tick();
    idle(); p2(1, 0, 10'h020, 32'h0, 4'h0); tick();

    idle(); p1(1, 0, 10'd0, 32'h0, 4'h0); tick();
    idle(); p1(1, 0, 10'd1, 32'h0, 4'h0); tick();
    idle(); clken = 1'b0;
    p1(0, 1, 10'd2, 32'hCAFEF00D, 4'hF); p2(0, 1, 10'd3, 32'hBAADC0DE, 4'hF); tick();
    tick();
    idle(); p1(1, 0, 10'd2, 32'h0, 4'h0); tick();
    idle(); p1(1, 0, 10'd3, 32'h0, 4'h0); tick();
    idle(); repeat (4) tick();

    // Reset lands after the accept edge but before either latency's valid is observed.
    idle(); p1(1, 0, 10'h005, 32'h0, 4'h0); tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d[k].delete();
      exp_t[k].delete();
    end
    idle(); #1;
    chk_idle_outputs("reset_midread");
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_idle_outputs("after_reset");
    idle(); p1(1, 0, 10'h005, 32'h0, 4'h0); p2(1, 0, 10'h3FF, 32'h0, 4'h0); tick();
    idle(); repeat (3) tick();

    for (int i = 0; i < 400; i++) begin
      idle();
      clken     = ($urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 15) == 0);
      s1_chipselect = ($urandom_range(0, 3) != 0);
      s1_read = $urandom_range(0, 1) == 1;
      s1_write = $urandom_range(0, 2) == 0;
      s1_address = pick_addr();
      s1_writedata = $urandom;
      s1_byteenable = 4'($urandom);
      s2_chipselect = ($urandom_range(0, 3) != 0);
      s2_read = $urandom_range(0, 1) == 1;
      s2_write = $urandom_range(0, 2) == 0;
      s2_address = ($urandom_range(0, 3) == 0) ? s1_address : pick_addr();
      s2_writedata = $urandom;
      s2_byteenable = 4'($urandom);
      tick();
    end

    idle(); repeat (6) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("drain_stream%0d", k), exp_d[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
